edge_gen: RTL and testbench

- Transmit-side counterpart of the edge detector on the 3-bit RGB level lines.
- Takes per-channel rise/fall edge requests and drives registered, glitch-free output levels.
- Guarantees a programmable minimum level hold time, so that every accepted edge is seen by the downstream detector as exactly one rising or falling pulse.
- Each channel has a one-deep pending slot for requests that arrive during the hold time. Channels are fully independent.

---
 rtl/edge_gen_if.sv | 20 ++
 rtl/edge_gen.sv | 82 ++++++++
 tb/tb_edge_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/edge_gen_if.sv
// Request and level bundle between an edge requester and edge_gen.
// Each vector holds one bit per RGB channel.
interface edge_gen_if;
  logic [2:0] rise_req;
  logic [2:0] fall_req;
  logic [2:0] data_out;
  logic [2:0] busy;
  logic [2:0] pend;
  logic [2:0] req_err;

  modport master (
    output rise_req, fall_req,
    input  data_out, busy, pend, req_err
  );

  modport slave (
    input  rise_req, fall_req,
    output data_out, busy, pend, req_err
  );
endinterface

// File: rtl/edge_gen.sv
// Edge generator for the 3-bit RGB level lines.
// Holds each level for at least MIN_W cycles and stores one deferred edge per channel.
module edge_gen #(
  parameter int CNT_W = 8,
  parameter int MIN_W = 4
) (
  input logic       clk,
  input logic       rst,
  edge_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_W - 1);

  logic [2:0]       level_q, level_d;
  logic [2:0]       pend_valid_q, pend_valid_d;
  logic [2:0]       pend_dir_q, pend_dir_d;
  logic [2:0]       req_err_q, req_err_d;
  logic [2:0]       req_valid;
  logic [2:0]       busy_vec;
  logic [CNT_W-1:0] hold_q [3];
  logic [CNT_W-1:0] hold_d [3];

  // A request counts only when exactly one direction is asserted.
  assign req_valid = bus.rise_req ^ bus.fall_req;

  always_comb begin
    level_d      = level_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    req_err_d    = bus.rise_req & bus.fall_req;
    for (int i = 0; i < 3; i++) begin
      hold_d[i] = hold_q[i];
      if (hold_q[i] != '0) begin
        hold_d[i] = hold_q[i] - CNT_W'(1);
        if (req_valid[i]) begin
          pend_valid_d[i] = (bus.rise_req[i] != level_q[i]);
          pend_dir_d[i]   = bus.rise_req[i];
        end
      end else if (pend_valid_q[i]) begin
        // Apply the stored edge; a same-cycle request is judged against the new level.
        level_d[i] = pend_dir_q[i];
        hold_d[i]  = HOLD_LOAD;
        if (req_valid[i]) begin
          pend_valid_d[i] = (bus.rise_req[i] != pend_dir_q[i]);
          pend_dir_d[i]   = bus.rise_req[i];
        end else begin
          pend_valid_d[i] = 1'b0;
        end
      end else if (req_valid[i] && (bus.rise_req[i] != level_q[i])) begin
        level_d[i] = bus.rise_req[i];
        hold_d[i]  = HOLD_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q      <= '0;
      pend_valid_q <= '0;
      pend_dir_q   <= '0;
      req_err_q    <= '0;
      for (int i = 0; i < 3; i++) hold_q[i] <= '0;
    end else begin
      level_q      <= level_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      req_err_q    <= req_err_d;
      for (int i = 0; i < 3; i++) hold_q[i] <= hold_d[i];
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < 3; i++) busy_vec[i] = (hold_q[i] != '0);
  end

  assign bus.data_out = level_q;
  assign bus.busy     = busy_vec;
  assign bus.pend     = pend_valid_q;
  assign bus.req_err  = req_err_q;

endmodule

// File: tb/tb_edge_gen.sv
// Bench for edge_gen: directed scenarios plus random loopback on MIN_W=4 and MIN_W=1 instances.
// A cycle-timestamp model predicts every output each cycle.
module tb_edge_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  edge_gen_if bus4 ();
  edge_gen_if bus1 ();

  edge_gen #(.CNT_W(8), .MIN_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  edge_gen #(.CNT_W(8), .MIN_W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int minw [2] = '{4, 1};

  // Model: level, first cycle the level was visible, pending slot, error flag, edge count.
  int m_level [2][3];
  int m_tedge [2][3];
  int m_pv    [2][3];
  int m_pd    [2][3];
  int m_err   [2][3];
  int m_edges [2][3];

  int         o_rise    [2][3];
  int         o_fall    [2][3];
  int         run_start [2][3];
  bit         run_first [2][3];
  logic [2:0] prev_out  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_step(int d, int i, bit r, bit f, bit rs);
    bit free;
    int newlvl;
    if (rs) begin
      m_level[d][i] = 0;
      m_tedge[d][i] = -1000;
      m_pv[d][i]    = 0;
      m_pd[d][i]    = 0;
      m_err[d][i]   = 0;
      return;
    end
    m_err[d][i] = int'(r & f);
    free = (cyc - m_tedge[d][i]) >= (minw[d] - 1);
    if (!free) begin
      if (r ^ f) begin
        m_pv[d][i] = int'(r != m_level[d][i]);
        m_pd[d][i] = int'(r);
      end
    end else if (m_pv[d][i] != 0) begin
      newlvl        = m_pd[d][i];
      m_level[d][i] = newlvl;
      m_tedge[d][i] = cyc + 1;
      m_edges[d][i]++;
      if (r ^ f) begin
        m_pv[d][i] = int'(r != newlvl);
        m_pd[d][i] = int'(r);
      end else begin
        m_pv[d][i] = 0;
      end
    end else if ((r ^ f) && (r != m_level[d][i])) begin
      m_level[d][i] = int'(r);
      m_tedge[d][i] = cyc + 1;
      m_edges[d][i]++;
    end
  endfunction

  function automatic logic [2:0] exp_out(int d, int k);
    logic [2:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      case (k)
        0:       v[i] = (m_level[d][i] != 0);
        1:       v[i] = (cyc - m_tedge[d][i]) < (minw[d] - 1);
        2:       v[i] = (m_pv[d][i] != 0);
        default: v[i] = (m_err[d][i] != 0);
      endcase
    end
    return v;
  endfunction

  task automatic step(input logic [2:0] r, input logic [2:0] f, input bit rs);
    logic [2:0] cur;
    rst           = rs;
    bus4.rise_req = r;
    bus4.fall_req = f;
    bus1.rise_req = r;
    bus1.fall_req = f;
    @(posedge clk);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) model_step(d, i, r[i], f[i], rs);
    cyc++;
    #1;
    check("data_out_w4", bus4.data_out, exp_out(0, 0));
    check("busy_w4",     bus4.busy,     exp_out(0, 1));
    check("pend_w4",     bus4.pend,     exp_out(0, 2));
    check("req_err_w4",  bus4.req_err,  exp_out(0, 3));
    check("data_out_w1", bus1.data_out, exp_out(1, 0));
    check("busy_w1",     bus1.busy,     exp_out(1, 1));
    check("pend_w1",     bus1.pend,     exp_out(1, 2));
    check("req_err_w1",  bus1.req_err,  exp_out(1, 3));
    for (int d = 0; d < 2; d++) begin
      cur = (d == 0) ? bus4.data_out : bus1.data_out;
      for (int i = 0; i < 3; i++) begin
        if (rs) begin
          run_first[d][i] = 1'b1;
          run_start[d][i] = cyc;
        end else if (cur[i] !== prev_out[d][i]) begin
          if (cur[i]) o_rise[d][i]++;
          else        o_fall[d][i]++;
          if (!run_first[d][i])
            check("min_hold", 32'((cyc - run_start[d][i]) >= minw[d]), 32'd1);
          run_first[d][i] = 1'b0;
          run_start[d][i] = cyc;
        end
      end
      prev_out[d] = cur;
    end
  endtask

  initial begin
    logic [2:0] r, f;
    int sel;
    rst           = 1'b1;
    bus4.rise_req = '0;
    bus4.fall_req = '0;
    bus1.rise_req = '0;
    bus1.fall_req = '0;
    for (int d = 0; d < 2; d++) begin
      prev_out[d] = '0;
      for (int i = 0; i < 3; i++) begin
        m_edges[d][i] = 0;
        o_rise[d][i]  = 0;
        o_fall[d][i]  = 0;
      end
    end

    // Reset with rise requests held high.
    for (int k = 0; k < 3; k++) begin
      step(3'b111, 3'b000, 1'b1);
      check("rst_data", bus4.data_out, 3'b000);
      check("rst_busy", bus4.busy,     3'b000);
      check("rst_pend", bus4.pend,     3'b000);
      check("rst_err",  bus4.req_err,  3'b000);
    end

    // Hold/pending on ch0, conflict on ch1, cancel on ch2.
    while (cyc < 45) begin
      r = '0;
      f = '0;
      if (cyc == 10) r[0] = 1'b1;
      if (cyc == 11) f[0] = 1'b1;
      if (cyc == 20) begin r[1] = 1'b1; f[1] = 1'b1; end
      if (cyc == 30) r[2] = 1'b1;
      if (cyc == 31) f[2] = 1'b1;
      if (cyc == 32) r[2] = 1'b1;
      step(r, f, 1'b0);
      if (cyc >= 11 && cyc <= 18) begin
        check("hold_data0", bus4.data_out[0], cyc <= 14);
        check("hold_busy0", bus4.busy[0], (cyc <= 13) || (cyc >= 15 && cyc <= 17));
        check("hold_pend0", bus4.pend[0], cyc >= 12 && cyc <= 14);
      end
      if (cyc >= 20 && cyc <= 23) begin
        check("conf_err1",  bus4.req_err[1], cyc == 21);
        check("conf_data1", bus4.data_out[1], 1'b0);
        check("conf_busy1", bus4.busy[1], 1'b0);
        check("conf_pend1", bus4.pend[1], 1'b0);
      end
      if (cyc >= 31 && cyc <= 36) check("cancel_pend2", bus4.pend[2], cyc == 32);
      if (cyc >= 31 && cyc <= 40) check("cancel_data2", bus4.data_out[2], 1'b1);
    end

    // Reset while ch0 is holding with an edge pending.
    while (cyc < 61) begin
      r = '0;
      f = '0;
      if (cyc == 50) r[0] = 1'b1;
      if (cyc == 51) f[0] = 1'b1;
      if (cyc == 52) check("pre_rst_pend0", bus4.pend[0], 1'b1);
      step(r, f, cyc == 52);
      if (cyc >= 53) begin
        check("midrst_data", bus4.data_out, 3'b000);
        check("midrst_busy", bus4.busy,     3'b000);
        check("midrst_pend", bus4.pend,     3'b000);
      end
    end

    // Random loopback: edge counts seen on data_out must match applied edges.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) begin
        m_edges[d][i] = 0;
        o_rise[d][i]  = 0;
        o_fall[d][i]  = 0;
      end
    for (int n = 0; n < 2300; n++) begin
      for (int i = 0; i < 3; i++) begin
        sel  = (n < 2000) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
        r[i] = (sel == 1) || (sel == 3);
        f[i] = (sel == 2) || (sel == 3);
      end
      step(r, f, 1'b0);
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) begin
        check("edge_count", 32'(o_rise[d][i] + o_fall[d][i]), 32'(m_edges[d][i]));
        check("alternate", 32'((o_rise[d][i] == o_fall[d][i]) || (o_rise[d][i] == o_fall[d][i] + 1)), 32'd1);
      end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
